// File: rtl/gpu_fetch_pkg.sv
// Shared fetch-path definitions used by the IF stage and the PC-update unit.
package gpu_fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  // Redirect sources; any of these asserts flush into the fetch stage.
  typedef enum logic [2:0] {
    FLUSH_NONE     = 3'd0,
    FLUSH_TM_START = 3'd1,
    FLUSH_QUAL1    = 3'd2,
    FLUSH_QUAL2    = 3'd3,
    FLUSH_QUAL3    = 3'd4
  } flush_src_e;

  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// Skid slot plus output register between instruction memory and decode.
module if_skid_buffer #(
  parameter int DATA = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            rd_vld_i,
  input  logic [DATA-1:0] rd_data_i,
  input  logic [PC_W-1:0] rd_pc_i,
  input  logic            stall_i,
  output logic            skid_vld_o,
  output logic            out_vld_o,
  output logic [DATA-1:0] out_data_o,
  output logic [PC_W-1:0] out_pc_o
);
  import gpu_fetch_pkg::*;

  logic            skid_vld_q, skid_vld_d;
  logic [DATA-1:0] skid_data_q, skid_data_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic            out_vld_q, out_vld_d;
  logic [DATA-1:0] out_data_q, out_data_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic            may_load;

  assign may_load = !out_vld_q || !stall_i;

  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_pc_d    = out_pc_q;
    // Flush drops occupancy only; stale data stays visible behind valid=0.
    if (flush_i) begin
      skid_vld_d = 1'b0;
      out_vld_d  = 1'b0;
    end else if (may_load && skid_vld_q) begin
      out_vld_d  = 1'b1;
      out_data_d = skid_data_q;
      out_pc_d   = skid_pc_q;
      skid_vld_d = rd_vld_i;
      if (rd_vld_i) begin
        skid_data_d = rd_data_i;
        skid_pc_d   = rd_pc_i;
      end
    end else if (may_load && rd_vld_i) begin
      out_vld_d  = 1'b1;
      out_data_d = rd_data_i;
      out_pc_d   = rd_pc_i;
    end else if (rd_vld_i) begin
      skid_vld_d  = 1'b1;
      skid_data_d = rd_data_i;
      skid_pc_d   = rd_pc_i;
    end else if (may_load) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_pc_q    <= '0;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign skid_vld_o = skid_vld_q;
  assign out_vld_o  = out_vld_q;
  assign out_data_o = out_data_q;
  assign out_pc_o   = out_pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues imem reads and hands instructions to decode.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky misalign_err output.
module if_fetch_stage #(
  parameter int DATA = 32,
  parameter int ADDR = 12,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_in,
  input  logic            fetch_en,
  input  logic            flush,
  output logic            issue_ack,
  output logic            imem_rd_en,
  output logic [ADDR-1:0] imem_addr,
  input  logic [DATA-1:0] imem_rdata,
  input  logic            stall_in,
  output logic            valid_1,
  output logic            valid_2,
  output logic            valid_3,
  output logic [DATA-1:0] instr_out,
  output logic [PC_W-1:0] instr_pc_out
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);
  import gpu_fetch_pkg::*;

  localparam int ALIGN_LSB = $clog2(PC_STEP);

  logic            issue;
  logic            pc_ok;
  logic            valid_1_q, valid_1_d;
  logic [PC_W-1:0] pc_1_q, pc_1_d;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign pc_ok        = !pc_misaligned(pc_in[1:0]);
  assign misalign_d   = misalign_q || (fetch_en && !pc_ok);
  assign misalign_err = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  assign pc_ok = 1'b1;
`endif

  // Blocking on in-flight+held+stall keeps the skid slot from ever overflowing.
  assign issue = !rst && fetch_en && pc_ok && !flush && !valid_2 &&
                 !(valid_1_q && valid_3 && stall_in);

  assign issue_ack  = issue;
  assign imem_rd_en = issue;
  assign imem_addr  = pc_in[ALIGN_LSB +: ADDR];

  assign valid_1_d = issue;
  assign pc_1_d    = issue ? pc_in : pc_1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_1_q <= 1'b0;
      pc_1_q    <= '0;
    end else begin
      valid_1_q <= valid_1_d;
      pc_1_q    <= pc_1_d;
    end
  end

  assign valid_1 = valid_1_q;

  if_skid_buffer #(
    .DATA (DATA),
    .PC_W (PC_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .rd_vld_i   (valid_1_q),
    .rd_data_i  (imem_rdata),
    .rd_pc_i    (pc_1_q),
    .stall_i    (stall_in),
    .skid_vld_o (valid_2),
    .out_vld_o  (valid_3),
    .out_data_o (instr_out),
    .out_pc_o   (instr_pc_out)
  );

endmodule
